// File: rtl/ssbcc_uart_rx_inport.sv
// 8N1 UART receiver for the 9x8 core inport bus: synchronizer, bit-timing FSM
// and a small circular FIFO that the core drains through its read strobe.
module ssbcc_uart_rx_inport #(
  parameter int G_CLOCK_DIV  = 8,
  parameter int G_FIFO_DEPTH = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_rd,
  input  logic       i_clr_overflow,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_overflow,
  output logic       o_framing_err,
  output logic [1:0] o_state
);

  localparam int CW = $clog2(G_CLOCK_DIV);
  localparam int AW = $clog2(G_FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_HALF = CW'(G_CLOCK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(G_CLOCK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic            sync1, s_rx;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shift, shift_n;
  logic            push_req, ferr_n, expire;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      mem [G_FIFO_DEPTH];
  logic            full, empty, push, pop, ovf_set;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1 <= 1'b1;
      s_rx  <= 1'b1;
    end else begin
      sync1 <= i_rx;
      s_rx  <= sync1;
    end
  end

  // Counter counts down to zero; loading N-1 makes expiry land N edges later.
  assign expire = (cnt == '0);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shift_n  = shift;
    push_req = 1'b0;
    ferr_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!s_rx) begin
          cnt_n   = CNT_HALF;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (!expire) begin
          cnt_n = cnt - 1'b1;
        end else if (s_rx) begin
          state_n = ST_IDLE;
        end else begin
          cnt_n   = CNT_FULL;
          idx_n   = 3'd0;
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!expire) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n = {s_rx, shift[7:1]};
          cnt_n   = CNT_FULL;
          idx_n   = idx + 1'b1;
          if (idx == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (!expire) begin
          cnt_n = cnt - 1'b1;
        end else begin
          state_n = ST_IDLE;
          if (s_rx) push_req = 1'b1;
          else      ferr_n   = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = i_rd && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push    = push_req && (!full || pop);
  assign ovf_set = push_req && full && !pop;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_overflow    <= 1'b0;
      o_framing_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      o_framing_err <= ferr_n;
      if (ovf_set)             o_overflow <= 1'b1;
      else if (i_clr_overflow) o_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shift;
  end

  assign o_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign o_empty = empty;
  assign o_state = state;

endmodule

// File: tb/tb_ssbcc_uart_rx_inport.sv
// Directed bench for ssbcc_uart_rx_inport: frame timing, glitch rejection,
// framing errors, overflow, pop-on-full and mid-frame reset.
module tb_ssbcc_uart_rx_inport;

  localparam int CD = 8;

  logic       i_clk;
  logic       i_rst;
  logic       i_rx;
  logic       i_rd;
  logic       i_clr_overflow;
  logic [7:0] o_data;
  logic       o_empty;
  logic       o_overflow;
  logic       o_framing_err;
  logic [1:0] o_state;

  int n_cmp;
  int n_fail;
  int ferr_cnt;

  ssbcc_uart_rx_inport #(.G_CLOCK_DIV(CD), .G_FIFO_DEPTH(16)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_rx(i_rx),
    .i_rd(i_rd),
    .i_clr_overflow(i_clr_overflow),
    .o_data(o_data),
    .o_empty(o_empty),
    .o_overflow(o_overflow),
    .o_framing_err(o_framing_err),
    .o_state(o_state)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) if (o_framing_err === 1'b1) ferr_cnt++;

  // Called #1 after a rising edge; returns #1 after the 80th edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    repeat (CD) @(posedge i_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CD) @(posedge i_clk);
      #1;
    end
    i_rx = stop_bit;
    repeat (CD) @(posedge i_clk);
    #1;
    i_rx = 1'b1;
  endtask

  task automatic pop_one();
    i_rd = 1'b1;
    @(posedge i_clk);
    #1;
    i_rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_rx = 1'b1; i_rd = 1'b0; i_clr_overflow = 1'b0;
    idle(3);
    i_rst = 1'b1;
    idle(2);
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
    n_cmp++;
    if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", o_overflow); end
    n_cmp++;
    if (o_framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", o_framing_err); end
    n_cmp++;
    if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_state); end
  endtask

  task automatic test_frame_timing();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (78) @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_empty !== 1'b1) begin n_fail++; $display("FAIL timing_early: got empty=%b expected 1", o_empty); end
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_empty !== 1'b0) begin n_fail++; $display("FAIL timing_fall: got empty=%b expected 0", o_empty); end
        n_cmp++;
        if (o_data !== 8'hA5) begin n_fail++; $display("FAIL timing_data: got %h expected a5", o_data); end
      end
    join
    idle(4);
    pop_one();
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL pop_empty: got %b expected 1", o_empty); end
    pop_one();
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL rd_when_empty: got %b expected 1", o_empty); end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_cnt;
    i_rx = 1'b0;
    idle(2);
    i_rx = 1'b1;
    idle(2);
    n_cmp++;
    if (o_state !== 2'd1) begin n_fail++; $display("FAIL glitch_start: got state %0d expected 1", o_state); end
    idle(20);
    n_cmp++;
    if (o_state !== 2'd0) begin n_fail++; $display("FAIL glitch_idle: got state %0d expected 0", o_state); end
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL glitch_empty: got %b expected 1", o_empty); end
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL glitch_ovf: got %b expected 0", o_overflow); end
    n_cmp++;
    if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d pulses expected 0", ferr_cnt - f0); end
  endtask

  task automatic test_framing();
    int f0;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    idle(20);
    n_cmp++;
    if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d cycles expected 1", ferr_cnt - f0); end
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL ferr_empty: got %b expected 1", o_empty); end
    send_frame(8'h5A, 1'b1);
    n_cmp++;
    if (o_data !== 8'h5A || o_empty !== 1'b0) begin
      n_fail++; $display("FAIL after_ferr_data: got %h empty=%b expected 5a empty=0", o_data, o_empty);
    end
    pop_one();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", o_overflow); end
    send_frame(8'h10, 1'b1);
    n_cmp++;
    if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", o_overflow); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (o_data !== 8'(i) || o_empty !== 1'b0) begin
        n_fail++; $display("FAIL ovf_read%0d: got %h empty=%b expected %h", i, o_data, o_empty, 8'(i));
      end
      pop_one();
    end
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got %b expected 1", o_empty); end
    i_clr_overflow = 1'b1;
    idle(1);
    i_clr_overflow = 1'b0;
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", o_overflow); end
  endtask

  task automatic test_pop_on_full();
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
    fork
      send_frame(8'h30, 1'b1);
      begin
        repeat (78) @(posedge i_clk);
        #1;
        i_rd = 1'b1;
        @(posedge i_clk);
        #1;
        i_rd = 1'b0;
      end
    join
    n_cmp++;
    if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL popfull_ovf: got %b expected 0", o_overflow); end
    for (int i = 1; i <= 16; i++) begin
      n_cmp++;
      if (o_data !== 8'h20 + 8'(i) || o_empty !== 1'b0) begin
        n_fail++; $display("FAIL popfull_read%0d: got %h empty=%b expected %h", i, o_data, o_empty, 8'h20 + 8'(i));
      end
      pop_one();
    end
    n_cmp++;
    if (o_empty !== 1'b1) begin n_fail++; $display("FAIL popfull_count: got empty=%b expected 1", o_empty); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int f0;
    b = 8'h6B;
    send_frame(8'h11, 1'b1);
    n_cmp++;
    if (o_empty !== 1'b0) begin n_fail++; $display("FAIL rst_preload: got empty=%b expected 0", o_empty); end
    i_rx = 1'b0;
    idle(CD);
    for (int i = 0; i < 4; i++) begin
      i_rx = b[i];
      idle(CD);
    end
    i_rx = b[4];
    idle(2);
    n_cmp++;
    if (o_state !== 2'd2) begin n_fail++; $display("FAIL rst_in_data: got state %0d expected 2", o_state); end
    i_rst = 1'b0;
    #1;
    n_cmp++;
    if (o_empty !== 1'b1 || o_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_async: got empty=%b state=%0d expected empty=1 state=0", o_empty, o_state);
    end
    i_rx = 1'b1;
    idle(3);
    i_rst = 1'b1;
    idle(20);
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1);
    n_cmp++;
    if (o_data !== 8'h81 || o_empty !== 1'b0 || ferr_cnt !== f0) begin
      n_fail++; $display("FAIL rst_recover: got %h empty=%b ferr=%0d expected 81 empty=0 ferr=0", o_data, o_empty, ferr_cnt - f0);
    end
    pop_one();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    ferr_cnt = 0;
    test_reset();
    test_frame_timing();
    test_glitch();
    test_framing();
    test_overflow();
    test_pop_on_full();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ssbcc_uart_rx_inport.md
# ssbcc_uart_rx_inport

Serial UART receiver peripheral for the 9x8 core's input-port bus. It deserializes 8N1 frames from an external line into a small FIFO. The core reads the FIFO head through an inport and pops it with the inport read strobe. It is the receive-side counterpart of the core's output-port UART transmit path, and sits between a board pin and the core's inport mux.

## Interface
- G_CLOCK_DIV, 8, i_clk cycles per serial bit; even integer, minimum 4.
- G_FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.

- i_clk  input  1  processor clock; all logic on rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_rx  input  1  asynchronous serial line; idles high.
- i_rd  input  1  inport read strobe; pops the FIFO head when asserted and not empty.
- i_clr_overflow  input  1  clears o_overflow.
- o_data  output  8  FIFO head byte; valid while o_empty=0.
- o_empty  output  1  FIFO empty.
- o_overflow  output  1  sticky flag: a received byte was dropped because the FIFO was full.
- o_framing_err  output  1  one-cycle pulse: a stop bit was sampled low.

## Operation
- i_rx passes through a 2-flop synchronizer; both flops reset to 1. All rx logic uses the synchronized value s_rx.
- FSM states: IDLE, START, DATA, STOP. A bit counter (0..G_CLOCK_DIV-1) and a 3-bit data index support the FSM.
- IDLE: when s_rx=0, load the bit counter for G_CLOCK_DIV/2 and go to START.
- START: on expiry, if s_rx=1 (glitch), return to IDLE with no other effect. Otherwise reload G_CLOCK_DIV and go to DATA.
- DATA: on each expiry, shift s_rx into the shift register LSB-first and reload G_CLOCK_DIV. After bit 7 is sampled, go to STOP.
- STOP: on expiry, sample s_rx. If s_rx=1, push the byte when the FIFO is not full; when the FIFO is full, drop the byte and set o_overflow. If s_rx=0, pulse o_framing_err and discard the byte. In all cases return to IDLE on the same edge.
- FIFO: circular buffer with read/write pointers of log2(G_FIFO_DEPTH)+1 bits. Full when the pointers differ only in the MSB. o_data is the entry at the read pointer, read combinationally from the pointer register.
- i_rd while empty: ignored.
- Push and pop on the same edge: both occur. When full, the pop frees the slot, the push is accepted, and o_overflow is not set. When empty, the push is accepted and the pop is ignored.
- i_clr_overflow and a new overflow on the same edge: set wins.
- Reset (asynchronous, any time, including mid-frame): FSM to IDLE, FIFO emptied. Reset values: o_empty=1, o_data=0x00 (the memory is not cleared; o_data is forced to 0 while empty is permitted, but not required), o_overflow=0, o_framing_err=0.

## Timing
- Synchronizer latency: 2 cycles from an i_rx edge to s_rx.
- Let T0 be the first edge at which IDLE sees s_rx=0. Sample points:
  - start check at T0+G_CLOCK_DIV/2;
  - data bit k at T0+G_CLOCK_DIV/2+(k+1)*G_CLOCK_DIV;
  - stop bit at T0+G_CLOCK_DIV/2+9*G_CLOCK_DIV.
- Push occurs on the stop-sample edge. o_empty falls, and o_data is valid, one cycle later.
- o_framing_err is high for the one cycle following the stop-sample edge.
- Back-to-back frames: a start bit can be detected on the cycle after the stop sample, so there are no lost frames at full line rate.
- Pop: o_data shows the next entry, or o_empty rises, the cycle after the i_rd edge.

## Test plan
- With G_CLOCK_DIV=8, send 0xA5 as 8N1 -> o_empty falls exactly 2+4+72+1 cycles after the i_rx falling edge, o_data=0xA5. Pulse i_rd once -> o_empty=1 on the next cycle.
- Drive i_rx low for 2 cycles only -> FSM returns to IDLE, and o_empty, o_framing_err and o_overflow remain unchanged.
- Send 0x3C with the stop bit low -> o_framing_err pulses for 1 cycle, FIFO stays empty. A following good 0x5A frame -> o_data=0x5A.
- Send 17 bytes 0x00..0x10 with no reads -> o_overflow=1, and 16 reads return 0x00..0x0F. Pulse i_clr_overflow -> o_overflow=0.
- Fill the FIFO with 16 bytes, then assert i_rd exactly on the 17th frame's stop-sample edge -> o_overflow stays 0, the FIFO still holds 16 entries, and the last entry read is the 17th byte.
- Assert i_rst low during data bit 4 of a frame -> immediately o_empty=1 and the FSM is in IDLE. A clean frame 0x81 sent after reset release -> o_data=0x81.
